out_port_bcd_seg: RTL and testbench
===================================

Name: out_port_bcd_seg

Overview:
Sequential binary-to-decimal display stage that consumes one 32-bit CPU output port (out_port0/1/2) and drives six 7-segment digits (HEX5..HEX0) with the value in decimal.
- Sits directly downstream of sc_computer; one instance per output port.
- Uses an iterative shift-add-3 (double-dabble) engine with automatic re-conversion whenever the port value changes.
- Shows dashes when the value exceeds six decimal digits.

Parameters:
BLANK_LZ, 1, 1 = blank leading-zero digits (HEX0 always shown); 0 = show all six digits.
DATA_W, 32, width of the input port value.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset; clears all state immediately.
value  input  DATA_W  unsigned port value from the CPU; may change on any cycle.
HEX0  output  7  least-significant decimal digit, active-low segments, bit6=g .. bit0=a.
HEX1..HEX5  output  7 each  higher digits, same encoding; HEX5 = hundred-thousands.
busy  output  1  high while a conversion is in progress.
ovf  output  1  high while the displayed value is an overflow (value > 999999).

Behaviour:
- Segment codes, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash=0111111.
- Registers: last_conv[DATA_W], work[19:0], bcd[23:0] (six nibbles), cnt[4:0], disp[23:0], ovf, state.
- Reset (reset=0, async): state=IDLE; last_conv=0; disp=0; ovf=0; busy=0; cnt=0.
  - HEX outputs after reset: HEX0=1000000; HEX1..5=1111111 if BLANK_LZ=1, otherwise 1000000.
- States: IDLE, SHIFT, DONE.
- IDLE: each edge compare value with last_conv.
  - Equal: stay in IDLE.
  - Differ, at edge E0: last_conv<=value.
  - If value > 999999: ovf_next=1, go to DONE.
  - Otherwise: work<=value[19:0], bcd<=0, cnt<=0, ovf_next=0, go to SHIFT.
- SHIFT, edges E1..E20: each edge, first add 3 to every bcd nibble that is >=5, then shift {bcd,work} left by 1.
  - cnt increments each edge; after the 20th shift (cnt==19), go to DONE.
- DONE, one edge (E21, or E1 for overflow): disp<=bcd (don't-care when overflowing), ovf<=ovf_next, go to IDLE.
- Latency: display updates at E21 for an in-range value, and at E1 for an overflow value.
- busy=1 in SHIFT and DONE, 0 in IDLE; it is combinational from state.
- value changes during SHIFT/DONE are ignored by the engine. IDLE re-detects the mismatch, so the final stable value is always displayed eventually. No intermediate or mixed result is ever shown.
- Display mapping:
  - ovf=1: all six HEX = dash.
  - ovf=0: HEXi = code(disp[4i+3:4i]).
  - With BLANK_LZ=1, digit i>0 is blank when nibbles i..5 are all zero.
- Outputs are registered-state-derived combinational decode; no glitch requirement beyond that.
- Reset asserted mid-SHIFT aborts the conversion and gives the reset display. After release, a nonzero value is reconverted; value=0 needs no conversion (already shown).
- DATA_W < 20: zero-extend into work; the overflow compare still applies.

Decomposition:
- Package out_port_seg_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - MAX_DEC=999999;
  - N_SHIFT=20;
  - segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
- Sub-module seg7_digit (inputs: bcd[3:0], blank, dash; output: seg[6:0]); instantiated six times; dash has priority over blank.

Test Plan:
1. Hold reset=0 with value=555 -> HEX0=1000000, HEX1..5=1111111, busy=0, ovf=0. Release: busy rises next edge and stays high exactly 21 cycles, then HEX2..0 show 5,5,5 and HEX5..3 are blank.
2. value=123456 -> after 21 edges HEX5..HEX0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010.
3. value=7 with BLANK_LZ=1 -> HEX0=1111000, rest 1111111. With BLANK_LZ=0 -> HEX1..5=1000000.
4. value=1000000 -> ovf=1 and all HEX=0111111 one edge after detection, with busy high 1 cycle. Then value=999999 -> ovf=0 and all HEX=0010000.
5. value 42, then 99 applied during SHIFT cycle 5 -> display shows 42 first, then busy re-asserts and 99 appears 22 edges later. No other value appears.
6. Assert reset mid-SHIFT while converting 800000 -> display returns to reset state immediately. After release, 800000 appears after 21 busy cycles.

Source files
------------

// File: rtl/out_port_seg_pkg.sv
// ----------------------------------------------------------------------------
// out_port_seg_pkg
//   Shared types, constants and helper functions for the out_port_bcd_seg
//   decimal display stage.
//   - state_e     : conversion engine states (IDLE / SHIFT / DONE)
//   - MAX_DEC     : largest value that fits in six decimal digits
//   - N_SHIFT     : number of double-dabble shift steps (20-bit work register)
//   - SEG_*       : active-low 7-segment codes, bit6=g .. bit0=a
//   - seg_decode  : BCD nibble -> segment code
//   - bcd_add3    : the "add 3 to every nibble >= 5" correction step
// ----------------------------------------------------------------------------
package out_port_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int MAX_DEC  = 999999;
    localparam int N_SHIFT  = 20;
    localparam int N_DIGITS = 6;
    localparam int WORK_W   = 20;
    localparam int BCD_W    = 4 * N_DIGITS;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Map one BCD nibble to its segment pattern; codes 10..15 can never
    // reach the display and are shown as blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// ----------------------------------------------------------------------------
// seg7_digit
//   One 7-segment digit decoder with blank and dash overrides.
//   Ports:
//     bcd   in  [3:0]  decimal digit to show
//     blank in         force all segments off
//     dash  in         force the middle segment only (takes priority over blank)
//     seg   out [6:0]  active-low segments, bit6=g .. bit0=a
// ----------------------------------------------------------------------------
module seg7_digit
    import out_port_seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // Override selection: dash beats blank beats the decoded digit.
    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = seg_decode(bcd);
        end
    end

endmodule

// File: rtl/out_port_bcd_seg.sv
// ----------------------------------------------------------------------------
// out_port_bcd_seg
//   Shows one CPU output port value in decimal on six 7-segment digits.
//   A sequential shift-add-3 engine re-converts automatically whenever the
//   port value differs from the last value converted; values above 999999
//   are shown as six dashes.
//   Parameters:
//     BLANK_LZ  1 = blank leading-zero digits (HEX0 always lit), 0 = show all
//     DATA_W    width of the port value
//   Ports:
//     clk        in            rising-edge clock
//     reset      in            asynchronous, active-low reset
//     value      in  [DATA_W]  unsigned port value
//     HEX0..HEX5 out [6:0]     active-low segments, HEX0 = units digit
//     busy       out           conversion in progress (SHIFT or DONE)
//     ovf        out           displayed value is an overflow
// ----------------------------------------------------------------------------
module out_port_bcd_seg
    import out_port_seg_pkg::*;
#(
    parameter int BLANK_LZ = 1,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5,
    output logic              busy,
    output logic              ovf
);

    // Narrow ports are zero-extended to at least the 20-bit work width so the
    // range compare and the work load use the same vector.
    localparam int          EXT_W    = (DATA_W > WORK_W) ? DATA_W : WORK_W;
    localparam logic [4:0]  LAST_CNT = 5'(N_SHIFT - 1);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    last_conv_q, last_conv_d;
    logic [WORK_W-1:0]    work_q, work_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [BCD_W-1:0]     disp_q, disp_d;
    logic                 ovf_q, ovf_d;
    logic                 ovf_next_q, ovf_next_d;

    logic [EXT_W-1:0]     value_ext_s;
    logic                 value_changed_s;
    logic                 in_range_s;
    logic [BCD_W-1:0]     bcd_adj_s;
    logic [N_DIGITS-1:0]  blank_s;
    logic [6:0]           seg_s [N_DIGITS];

    assign value_ext_s     = EXT_W'(value);
    assign value_changed_s = (value != last_conv_q);
    assign in_range_s      = (value_ext_s <= EXT_W'(MAX_DEC));
    assign bcd_adj_s       = bcd_add3(bcd_q);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_conv_q <= '0;
            work_q      <= '0;
            bcd_q       <= '0;
            cnt_q       <= 5'd0;
            disp_q      <= '0;
            ovf_q       <= 1'b0;
            ovf_next_q  <= 1'b0;
        end else begin
            last_conv_q <= last_conv_d;
            work_q      <= work_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            ovf_q       <= ovf_d;
            ovf_next_q  <= ovf_next_d;
        end
    end

    // Next-state logic: overflow values skip the shift phase entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (value_changed_s) begin
                    if (in_range_s) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. The value is captured only in IDLE, so changes
    // during SHIFT/DONE are picked up by the next IDLE compare and the display
    // only ever receives a fully converted result.
    always_comb begin
        last_conv_d = last_conv_q;
        work_d      = work_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        disp_d      = disp_q;
        ovf_d       = ovf_q;
        ovf_next_d  = ovf_next_q;
        case (state_q)
            IDLE: begin
                if (value_changed_s) begin
                    last_conv_d = value;
                    if (in_range_s) begin
                        work_d     = value_ext_s[WORK_W-1:0];
                        bcd_d      = '0;
                        cnt_d      = 5'd0;
                        ovf_next_d = 1'b0;
                    end else begin
                        ovf_next_d = 1'b1;
                    end
                end else begin
                    last_conv_d = last_conv_q;
                end
            end
            SHIFT: begin
                // Correct, then shift {bcd, work} left by one bit.
                {bcd_d, work_d} = {bcd_adj_s[BCD_W-2:0], work_q, 1'b0};
                cnt_d           = cnt_q + 5'd1;
            end
            DONE: begin
                // On overflow the stale bcd is loaded but masked by ovf.
                disp_d = bcd_q;
                ovf_d  = ovf_next_q;
            end
            default: begin
                cnt_d = 5'd0;
            end
        endcase
    end

    // FSM output.
    always_comb begin
        busy = 1'b0;
        if (state_q != IDLE) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

    // Leading-zero blanking: digit i>0 goes dark when it and every higher
    // digit are zero. HEX0 is never blanked so zero still reads as "0".
    always_comb begin
        blank_s = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if ((BLANK_LZ != 0) && ((disp_q >> (4 * i)) == 24'd0)) begin
                blank_s[i] = 1'b1;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        seg7_digit u_digit (
            .bcd   (disp_q[4*g +: 4]),
            .blank (blank_s[g]),
            .dash  (ovf_q),
            .seg   (seg_s[g])
        );
    end

    assign HEX0 = seg_s[0];
    assign HEX1 = seg_s[1];
    assign HEX2 = seg_s[2];
    assign HEX3 = seg_s[3];
    assign HEX4 = seg_s[4];
    assign HEX5 = seg_s[5];
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_out_port_bcd_seg.sv
// ----------------------------------------------------------------------------
// tb_out_port_bcd_seg
//   Drives two instances (BLANK_LZ=1 and BLANK_LZ=0) from the same value.
//   Stimulus pushes hand-written expected displays into a queue; a monitor
//   pops one entry each time busy falls and compares both displays, ovf,
//   the busy length and that the display held still while busy.
// ----------------------------------------------------------------------------
module tb_out_port_bcd_seg;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    localparam logic [41:0] RST_B = {SB, SB, SB, SB, SB, S0};
    localparam logic [41:0] RST_Z = {S0, S0, S0, S0, S0, S0};

    typedef struct {
        string       name;
        logic [41:0] hex_b;
        logic [41:0] hex_z;
        logic        ovf;
        int          busy_len;
    } exp_t;

    exp_t sb_q[$];

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic [6:0]  b0, b1, b2, b3, b4, b5;
    logic [6:0]  z0, z1, z2, z3, z4, z5;
    logic        busy, ovf, busy_z, ovf_z;
    logic [41:0] hex_b_s, hex_z_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    out_port_bcd_seg #(.BLANK_LZ(1), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .value(value),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5),
        .busy(busy), .ovf(ovf)
    );

    out_port_bcd_seg #(.BLANK_LZ(0), .DATA_W(32)) dut_z (
        .clk(clk), .reset(reset), .value(value),
        .HEX0(z0), .HEX1(z1), .HEX2(z2), .HEX3(z3), .HEX4(z4), .HEX5(z5),
        .busy(busy_z), .ovf(ovf_z)
    );

    assign hex_b_s = {b5, b4, b3, b2, b1, b0};
    assign hex_z_s = {z5, z4, z3, z2, z1, z0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [41:0] hb, input logic [41:0] hz,
                        input logic o, input int len);
        exp_t e;
        e.name = name; e.hex_b = hb; e.hex_z = hz; e.ovf = o; e.busy_len = len;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout: pending=%0d, want 0", sb_q.size());
        sb_q.delete();
    endtask

    task automatic apply(input logic [31:0] v, input string name, input logic [41:0] hb,
                         input logic [41:0] hz, input logic o, input int len);
        @(posedge clk);
        #2;
        push(name, hb, hz, o, len);
        value = v;
        wait_done(60);
    endtask

    // Monitor: compares one queued expectation per completed conversion.
    initial begin
        exp_t        e;
        int          busy_cnt;
        logic        prev_busy;
        logic        held_ok;
        logic [41:0] shown_b, shown_z;
        logic        shown_ovf;
        busy_cnt = 0; prev_busy = 1'b0; held_ok = 1'b1;
        shown_b = RST_B; shown_z = RST_Z; shown_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_cnt = 0; prev_busy = 1'b0; held_ok = 1'b1;
                shown_b = RST_B; shown_z = RST_Z; shown_ovf = 1'b0;
            end else begin
                if (busy) begin
                    busy_cnt++;
                    if (hex_b_s !== shown_b || hex_z_s !== shown_z ||
                        ovf !== shown_ovf || busy_z !== busy) held_ok = 1'b0;
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_conversion", 64'(busy_cnt), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_hex_blank"}, 64'(hex_b_s), 64'(e.hex_b));
                        check({e.name, "_hex_zeros"}, 64'(hex_z_s), 64'(e.hex_z));
                        check({e.name, "_ovf"}, 64'({ovf, ovf_z}), 64'({e.ovf, e.ovf}));
                        check({e.name, "_busy_len"}, 64'(busy_cnt), 64'(e.busy_len));
                        check({e.name, "_held"}, 64'(held_ok), 64'd1);
                        shown_b = e.hex_b; shown_z = e.hex_z; shown_ovf = e.ovf;
                    end
                    busy_cnt = 0;
                    held_ok  = 1'b1;
                end
                prev_busy = busy;
            end
        end
    end

    // Stimulus.
    initial begin
        int busy_seen;
        reset = 1'b0;
        value = 32'd555;
        repeat (3) @(negedge clk);
        check("reset_hex_blank", 64'(hex_b_s), 64'(RST_B));
        check("reset_hex_zeros", 64'(hex_z_s), 64'(RST_Z));
        check("reset_busy", 64'({busy, busy_z}), 64'd0);
        check("reset_ovf", 64'({ovf, ovf_z}), 64'd0);

        // 555 converts after release
        push("v555", {SB, SB, SB, S5, S5, S5}, {S0, S0, S0, S5, S5, S5}, 1'b0, 21);
        @(posedge clk);
        #2 reset = 1'b1;
        wait_done(60);

        apply(32'd123456, "v123456", {S1, S2, S3, S4, S5, S6}, {S1, S2, S3, S4, S5, S6}, 1'b0, 21);
        apply(32'd7, "v7", {SB, SB, SB, SB, SB, S7}, {S0, S0, S0, S0, S0, S7}, 1'b0, 21);
        apply(32'd1000, "v1000", {SB, SB, S1, S0, S0, S0}, {S0, S0, S1, S0, S0, S0}, 1'b0, 21);
        apply(32'd1000000, "v1000000", {SD, SD, SD, SD, SD, SD}, {SD, SD, SD, SD, SD, SD}, 1'b1, 1);
        apply(32'd999999, "v999999", {S9, S9, S9, S9, S9, S9}, {S9, S9, S9, S9, S9, S9}, 1'b0, 21);

        // value changes mid-conversion: 42 completes, then 99
        @(posedge clk);
        #2;
        push("v42", {SB, SB, SB, SB, S4, S2}, {S0, S0, S0, S0, S4, S2}, 1'b0, 21);
        push("v99", {SB, SB, SB, SB, S9, S9}, {S0, S0, S0, S0, S9, S9}, 1'b0, 21);
        value = 32'd42;
        repeat (6) @(posedge clk);
        #2 value = 32'd99;
        wait_done(100);

        // reset in the middle of converting 800000
        @(posedge clk);
        #2 value = 32'd800000;
        repeat (8) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("midreset_hex_blank", 64'(hex_b_s), 64'(RST_B));
        check("midreset_hex_zeros", 64'(hex_z_s), 64'(RST_Z));
        check("midreset_busy", 64'({busy, busy_z}), 64'd0);
        push("v800000", {S8, S0, S0, S0, S0, S0}, {S8, S0, S0, S0, S0, S0}, 1'b0, 21);
        @(posedge clk);
        #2 reset = 1'b1;
        wait_done(60);

        // value 0 after reset needs no conversion
        @(posedge clk);
        #2 begin reset = 1'b0; value = 32'd0; end
        @(posedge clk);
        #2 reset = 1'b1;
        busy_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("zero_no_busy", 64'(busy_seen), 64'd0);
        check("zero_hex_blank", 64'(hex_b_s), 64'(RST_B));

        check("queue_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
